// File: rtl/rf_wb_arbiter_if.sv
// Write-back request/grant bundle between the three result producers and the
// register-file write port arbiter.
interface rf_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [2:0]          req_valid;
  logic [3*ADDR_W-1:0] req_addr;
  logic [3*DATA_W-1:0] req_data;
  logic [2:0]          req_ready;
  logic                stall;
  logic                rf_we;
  logic [ADDR_W-1:0]   rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;
  logic [2:0]          busy;

  modport master (
    output req_valid, req_addr, req_data, stall,
    input  req_ready, rf_we, rf_waddr, rf_wdata, busy
  );

  modport slave (
    input  req_valid, req_addr, req_data, stall,
    output req_ready, rf_we, rf_waddr, rf_wdata, busy
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Three-way register-file write-back arbiter with a one-cycle registered write port.
// Define RF_ARB_RR_EN for round-robin arbitration; otherwise fixed priority req0 > req1 > req2.
module rf_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic            clk,
  input logic            rst,
  rf_wb_arbiter_if.slave bus
);

  logic [2:0]        grant;
  logic [1:0]        grant_idx;
  logic [1:0]        cand;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic              rf_we_d,    rf_we_q;
  logic [ADDR_W-1:0] rf_waddr_d, rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_d, rf_wdata_q;

`ifdef RF_ARB_RR_EN
  logic [1:0] ptr_d, ptr_q;
`endif

  // First valid requester in search order wins; search starts at the pointer in RR mode.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    if (!rst && !bus.stall) begin
      for (int unsigned k = 0; k < 3; k++) begin
`ifdef RF_ARB_RR_EN
        cand = 2'((32'(ptr_q) + k) % 3);
`else
        cand = 2'(k);
`endif
        if (grant == '0 && bus.req_valid[cand]) begin
          grant[cand] = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  assign sel_addr = bus.req_addr[grant_idx*ADDR_W +: ADDR_W];
  assign sel_data = bus.req_data[grant_idx*DATA_W +: DATA_W];

`ifdef RF_ARB_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    if (grant != '0) begin
      ptr_d = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
    end
  end
`endif

  // Writes to register 0 are accepted but never reach the register file.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (grant != '0) begin
      rf_we_d    = (sel_addr != '0);
      rf_waddr_d = sel_addr;
      rf_wdata_d = sel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
`ifdef RF_ARB_RR_EN
      ptr_q      <= '0;
`endif
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
`ifdef RF_ARB_RR_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign bus.req_ready = grant;
  assign bus.busy      = bus.req_valid & ~grant;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus randomized traffic
// against a behavioural model of the arbitration and write-back rules.
module tb_rf_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  rf_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic          m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  logic          m_ambig;   // last grant targeted r0: held addr/data are not compared
  int            m_ptr;

  function automatic logic [2:0] exp_grant(input logic [2:0] v, input logic st,
                                           input logic rs, input int p);
    if (st || rs) return 3'b000;
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (p + k) % 3;
      if (v[i]) return 3'(1 << i);
    end
    return 3'b000;
  endfunction

  always @(posedge clk) begin
    logic [2:0] g;
    g = exp_grant(bus.req_valid, bus.stall, rst, m_ptr);
    if (rst) begin
      m_we <= 1'b0; m_waddr <= '0; m_wdata <= '0; m_ambig <= 1'b0; m_ptr <= 0;
    end else if (g != 3'b000) begin
      for (int i = 0; i < 3; i++) begin
        if (g[i]) begin
          logic [AW-1:0] a;
          a = bus.req_addr[i*AW +: AW];
          m_we    <= (a != 0);
          m_waddr <= a;
          m_wdata <= bus.req_data[i*DW +: DW];
          m_ambig <= (a == 0);
`ifdef RF_ARB_RR_EN
          m_ptr   <= (i + 1) % 3;
`endif
        end
      end
    end else begin
      m_we <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; bus.stall = 1'b0; bus.req_valid = 3'b111;
    bus.req_addr = '1; bus.req_data = '1;
    tick();
    @(negedge clk);
    n_tests++; if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready got=%b exp=000", bus.req_ready); end
    n_tests++; if (bus.busy !== 3'b111) begin n_fail++; $display("FAIL reset_busy got=%b exp=111", bus.busy); end
    n_tests++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", bus.rf_we); end
    n_tests++; if (bus.rf_waddr !== '0 || bus.rf_wdata !== '0) begin n_fail++;
      $display("FAIL reset_addr_data got=%0d/%h exp=0/0", bus.rf_waddr, bus.rf_wdata); end
  endtask

  task automatic test_single();
    tick();
    rst = 1'b0; bus.req_valid = 3'b001;
    bus.req_addr = '0; bus.req_addr[0 +: AW] = 5'd7;
    bus.req_data = '0; bus.req_data[0 +: DW] = 32'hDEADBEEF;
    @(negedge clk);
    n_tests++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL single_ready got=%b exp=001", bus.req_ready); end
    tick();
    bus.req_valid = 3'b000;
    @(negedge clk);
    n_tests++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd7 || bus.rf_wdata !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL single_write got=%b/%0d/%h exp=1/7/deadbeef", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    tick();
    @(negedge clk);
    n_tests++; if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd7 || bus.rf_wdata !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL single_idle_hold got=%b/%0d/%h exp=0/7/deadbeef", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
  endtask

  task automatic test_contention();
    logic [2:0] seq [4];
    int prev;
`ifdef RF_ARB_RR_EN
    seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100; seq[3] = 3'b001;
`else
    seq[0] = 3'b001; seq[1] = 3'b001; seq[2] = 3'b001; seq[3] = 3'b001;
`endif
    rst = 1'b1; tick(); rst = 1'b0;
    bus.req_valid = 3'b111;
    bus.req_addr  = {5'd3, 5'd2, 5'd1};
    bus.req_data  = {32'hC0C0_0003, 32'hB0B0_0002, 32'hA0A0_0001};
    prev = -1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_tests++; if (bus.req_ready !== seq[k]) begin n_fail++; $display("FAIL contention_ready[%0d] got=%b exp=%b", k, bus.req_ready, seq[k]); end
      n_tests++; if (bus.busy !== (3'b111 & ~seq[k])) begin n_fail++; $display("FAIL contention_busy[%0d] got=%b exp=%b", k, bus.busy, 3'b111 & ~seq[k]); end
      if (prev >= 0) begin
        n_tests++;
        if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'(prev + 1) || bus.rf_wdata !== bus.req_data[prev*DW +: DW]) begin n_fail++;
          $display("FAIL contention_write[%0d] got=%b/%0d exp=1/%0d", k, bus.rf_we, bus.rf_waddr, prev + 1); end
      end
      for (int i = 0; i < 3; i++) if (seq[k][i]) prev = i;
      tick();
    end
    bus.req_valid = 3'b000;
  endtask

  task automatic test_addr_zero();
    bus.req_valid = 3'b001;
    bus.req_addr = '0;
    bus.req_data = '0; bus.req_data[0 +: DW] = 32'h12345678;
    @(negedge clk);
    n_tests++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL addr0_ready got=%b exp=001", bus.req_ready); end
    tick();
    bus.req_valid = 3'b000;
    @(negedge clk);
    n_tests++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL addr0_we got=%b exp=0", bus.rf_we); end
    tick();
  endtask

  task automatic test_stall();
    bus.stall = 1'b1; bus.req_valid = 3'b010;
    bus.req_addr = '0; bus.req_addr[AW +: AW] = 5'd5;
    bus.req_data = '0; bus.req_data[DW +: DW] = 32'h5A5A_0505;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++; if (bus.req_ready !== 3'b000 || bus.rf_we !== 1'b0 || bus.busy !== 3'b010) begin n_fail++;
        $display("FAIL stall_hold[%0d] ready=%b we=%b busy=%b exp=000/0/010", k, bus.req_ready, bus.rf_we, bus.busy); end
      tick();
    end
    bus.stall = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.req_ready !== 3'b010) begin n_fail++; $display("FAIL stall_release_ready got=%b exp=010", bus.req_ready); end
    tick();
    bus.req_valid = 3'b000;
    @(negedge clk);
    n_tests++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 32'h5A5A_0505) begin n_fail++;
      $display("FAIL stall_release_write got=%b/%0d/%h exp=1/5/5a5a0505", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    tick();
  endtask

  task automatic test_reset_after_grant();
    bus.req_valid = 3'b010;
    bus.req_addr = '0; bus.req_addr[AW +: AW] = 5'd9;
    bus.req_data = '0; bus.req_data[DW +: DW] = 32'h0000_0999;
    @(negedge clk);
    n_tests++; if (bus.req_ready !== 3'b010) begin n_fail++; $display("FAIL rag_grant got=%b exp=010", bus.req_ready); end
    tick();
    bus.req_valid = 3'b000; rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.rf_we !== 1'b0 || bus.rf_waddr !== '0 || bus.rf_wdata !== '0) begin n_fail++;
      $display("FAIL rag_cleared got=%b/%0d/%h exp=0/0/0", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    bus.req_valid = 3'b111;
    bus.req_addr = {5'd3, 5'd2, 5'd1};
    @(negedge clk);
    n_tests++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL rag_first_grant got=%b exp=001", bus.req_ready); end
    tick();
    bus.req_valid = 3'b000;
  endtask

  task automatic test_random();
    logic [2:0] eg;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      eg = exp_grant(bus.req_valid, bus.stall, rst, m_ptr);
      n_tests++; if (bus.req_ready !== eg) begin n_fail++; $display("FAIL rand_ready[%0d] got=%b exp=%b", c, bus.req_ready, eg); end
      n_tests++; if (bus.busy !== (bus.req_valid & ~eg)) begin n_fail++; $display("FAIL rand_busy[%0d] got=%b exp=%b", c, bus.busy, bus.req_valid & ~eg); end
      n_tests++; if (bus.rf_we !== m_we) begin n_fail++; $display("FAIL rand_we[%0d] got=%b exp=%b", c, bus.rf_we, m_we); end
      if (!m_ambig) begin
        n_tests++; if (bus.rf_waddr !== m_waddr || bus.rf_wdata !== m_wdata) begin n_fail++;
          $display("FAIL rand_wport[%0d] got=%0d/%h exp=%0d/%h", c, bus.rf_waddr, bus.rf_wdata, m_waddr, m_wdata); end
      end
      tick();
      // a requester keeps its request until the model says it was consumed
      for (int i = 0; i < 3; i++) begin
        if (!bus.req_valid[i] || eg[i]) begin
          bus.req_valid[i] = ($urandom_range(0, 3) != 0);
          bus.req_addr[i*AW +: AW] = AW'($urandom_range(0, 31));
          bus.req_data[i*DW +: DW] = $urandom;
        end
      end
      bus.stall = ($urandom_range(0, 4) == 0);
      rst = ($urandom_range(0, 40) == 0);
    end
    rst = 1'b0; bus.stall = 1'b0; bus.req_valid = 3'b000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_addr_zero();
    test_stall();
    test_reset_after_grant();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
